// File: rtl/mic_adc_sampler.sv
// Periodic SPI conversion on an external serial ADC; the top OUT_WIDTH bits of each
// conversion are presented on sample with a one-cycle sample_valid strobe.
module mic_adc_sampler #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1024,
    parameter int LEAD_BITS     = 3,
    parameter int ADC_BITS      = 12,
    parameter int OUT_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 adc_miso,
    output logic                 adc_sclk,
    output logic                 adc_cs_n,
    output logic [OUT_WIDTH-1:0] sample,
    output logic                 sample_valid,
    output logic                 busy
);

    // state   | meaning
    // IDLE    | cs_n high, sclk low, waiting for the sample tick
    // SETUP   | cs_n low, CLK_DIV cycles before the first sclk edge
    // SCLK_LO | sclk low phase; miso captured on its last cycle
    // SCLK_HI | sclk high phase; picks next bit or end of frame
    // DONE    | cs_n released, sample updated, strobe high

    localparam int FRAME_BITS = LEAD_BITS + ADC_BITS;
    localparam int TMR_W      = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W      = $clog2(FRAME_BITS + 1);

    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(SAMPLE_PERIOD - 1);
    localparam logic [DIV_W-1:0] DIV_LOAD  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_FINAL = BIT_W'(FRAME_BITS);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("mic_adc_sampler: CLK_DIV must be at least 1");
    end
    if (OUT_WIDTH > ADC_BITS || ADC_BITS < 2) begin : g_bad_width
        $error("mic_adc_sampler: need 2 <= ADC_BITS and OUT_WIDTH <= ADC_BITS");
    end
    if (SAMPLE_PERIOD <= CLK_DIV * (1 + 2 * FRAME_BITS) + 2) begin : g_bad_period
        $error("mic_adc_sampler: SAMPLE_PERIOD too short for one frame");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        SCLK_LO = 3'd2,
        SCLK_HI = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [TMR_W-1:0]       tmr_cnt;
    logic                   tick;
    logic [DIV_W-1:0]       phase_cnt;
    logic [DIV_W-1:0]       phase_nxt;
    logic                   phase_done;
    logic [BIT_W-1:0]       bit_cnt;
    logic [BIT_W-1:0]       bit_nxt;
    logic [ADC_BITS-1:0]    shift_reg;
    logic [ADC_BITS-1:0]    shift_nxt;
    logic [OUT_WIDTH-1:0]   sample_nxt;
    logic                   in_frame_nxt;

    assign tick       = en && (tmr_cnt == TMR_LAST);
    assign phase_done = (phase_cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr_cnt <= '0;
        end else if (!en || tick) begin
            tmr_cnt <= '0;
        end else begin
            tmr_cnt <= tmr_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            phase_cnt    <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            sample       <= '0;
            adc_cs_n     <= 1'b1;
            adc_sclk     <= 1'b0;
            sample_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            phase_cnt    <= phase_nxt;
            bit_cnt      <= bit_nxt;
            shift_reg    <= shift_nxt;
            sample       <= sample_nxt;
            adc_cs_n     <= ~in_frame_nxt;
            adc_sclk     <= (state_nxt == SCLK_HI);
            sample_valid <= (state_nxt == DONE);
        end
    end

    // Phase timing is a down-counter reloaded with CLK_DIV-1 on every state entry.
    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase_cnt;
        bit_nxt    = bit_cnt;
        shift_nxt  = shift_reg;
        sample_nxt = sample;
        case (state)
            IDLE: begin
                bit_nxt   = '0;
                phase_nxt = DIV_LOAD;
                if (tick) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (phase_done) begin
                    state_nxt = SCLK_LO;
                    phase_nxt = DIV_LOAD;
                end else begin
                    phase_nxt = phase_cnt - 1'b1;
                end
            end
            SCLK_LO: begin
                if (phase_done) begin
                    shift_nxt = {shift_reg[ADC_BITS-2:0], adc_miso};
                    bit_nxt   = bit_cnt + 1'b1;
                    state_nxt = SCLK_HI;
                    phase_nxt = DIV_LOAD;
                end else begin
                    phase_nxt = phase_cnt - 1'b1;
                end
            end
            SCLK_HI: begin
                if (phase_done) begin
                    phase_nxt = DIV_LOAD;
                    if (bit_cnt < BIT_FINAL) begin
                        state_nxt = SCLK_LO;
                    end else begin
                        state_nxt  = DONE;
                        sample_nxt = shift_reg[ADC_BITS-1 -: OUT_WIDTH];
                    end
                end else begin
                    phase_nxt = phase_cnt - 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign in_frame_nxt = (state_nxt == SETUP) || (state_nxt == SCLK_LO) ||
                          (state_nxt == SCLK_HI);

    assign busy = ~adc_cs_n;

endmodule

// File: tb/tb_mic_adc_sampler.sv
// Bench for mic_adc_sampler: default instance plus a CLK_DIV=1 / SAMPLE_PERIOD=40 instance,
// each checked every cycle against a frame-timing model, plus literal timing/sample checks.
module tb_mic_adc_sampler;

    localparam int FB = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       en0, en1;
    logic       miso0, miso1;
    logic       sclk0, cs0, valid0, busy0;
    logic       sclk1, cs1, valid1, busy1;
    logic [7:0] smp0, smp1;

    mic_adc_sampler u_dut0 (
        .clk(clk), .rst(rst), .en(en0), .adc_miso(miso0), .adc_sclk(sclk0),
        .adc_cs_n(cs0), .sample(smp0), .sample_valid(valid0), .busy(busy0)
    );

    mic_adc_sampler #(.CLK_DIV(1), .SAMPLE_PERIOD(40)) u_dut1 (
        .clk(clk), .rst(rst), .en(en1), .adc_miso(miso1), .adc_sclk(sclk1),
        .adc_cs_n(cs1), .sample(smp1), .sample_valid(valid1), .busy(busy1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int          div_p [2] = '{4, 1};
    int          per_p [2] = '{1024, 40};
    logic [11:0] word  [2];
    logic [2:0]  lead  [2];

    // ADC model: bit k of {lead, word} is on miso after the k-th sclk fall.
    int rise0 = 0;
    int rise1 = 0;
    always @(negedge sclk0 or posedge cs0) rise0 = cs0 ? 0 : rise0 + 1;
    always @(negedge sclk1 or posedge cs1) rise1 = cs1 ? 0 : rise1 + 1;

    function automatic logic frame_bit(logic [2:0] ld, logic [11:0] w, int idx);
        logic [14:0] f;
        f = {ld, w};
        if (idx < 0 || idx > 14) return 1'b0;
        return f[14 - idx];
    endfunction

    assign miso0 = frame_bit(lead[0], word[0], rise0);
    assign miso1 = frame_bit(lead[1], word[1], rise1);

    // Model state: en run length, frame start cycle, held sample.
    int         run      [2] = '{0, 0};
    bit         fr_on    [2] = '{0, 0};
    int         start    [2] = '{0, 0};
    logic [7:0] hold     [2] = '{8'h00, 8'h00};

    // Observations for literal checks.
    int         fall_cnt   [2] = '{0, 0};
    int         valid_cnt  [2] = '{0, 0};
    int         fall_cyc   [2] = '{0, 0};
    int         valid_cyc  [2] = '{0, 0};
    int         valid_prev [2] = '{0, 0};
    int         rises      [2] = '{0, 0};
    int         rises_fr   [2] = '{0, 0};
    logic [7:0] smp_v      [2] = '{8'h00, 8'h00};
    logic       cs_prev    [2] = '{1'b1, 1'b1};
    logic       sclk_prev  [2] = '{1'b0, 1'b0};

    task automatic chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    task automatic model_step(int i, logic en_i, logic cs, logic sclk, logic bsy,
                              logic vld, logic [7:0] smp);
        int         o;
        int         d;
        int         len;
        bit         done_now;
        bit         tick;
        logic       e_cs, e_sclk, e_busy, e_valid;
        logic [11:0] exp_v, act_v;
        d      = div_p[i];
        len    = d * (1 + 2 * FB);
        o      = cyc - start[i];
        e_cs   = 1'b1;
        e_sclk = 1'b0;
        e_busy = 1'b0;
        e_valid = 1'b0;
        if (!rst) begin
            run[i]   = 0;
            fr_on[i] = 1'b0;
            hold[i]  = 8'h00;
        end else if (fr_on[i] && o == len) begin
            e_valid = 1'b1;
            hold[i] = word[i][11:4];
        end else if (fr_on[i]) begin
            e_cs   = 1'b0;
            e_busy = 1'b1;
            e_sclk = (o >= d) && ((((o - d) / d) % 2) == 1);
        end
        exp_v = {e_cs, e_sclk, e_busy, e_valid, hold[i]};
        act_v = {cs, sclk, bsy, vld, smp};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL outputs dut%0d cycle %0d {cs_n,sclk,busy,valid,sample}: got %03h want %03h",
                     i, cyc, act_v, exp_v);
        end
        if (rst) begin
            done_now = fr_on[i] && (o == len);
            run[i]   = en_i ? run[i] + 1 : 0;
            tick     = en_i && ((run[i] % per_p[i]) == 0);
            if (done_now) begin
                fr_on[i] = 1'b0;
            end else if (!fr_on[i] && tick) begin
                fr_on[i] = 1'b1;
                start[i] = cyc + 1;
            end
        end
    endtask

    task automatic observe(int i, logic cs, logic sclk, logic vld, logic [7:0] smp);
        if (cs_prev[i] && !cs) begin
            fall_cyc[i] = cyc;
            fall_cnt[i]++;
            rises[i] = 0;
        end
        if (sclk && !sclk_prev[i]) rises[i]++;
        if (vld) begin
            valid_prev[i] = valid_cyc[i];
            valid_cyc[i]  = cyc;
            valid_cnt[i]++;
            smp_v[i]      = smp;
            rises_fr[i]   = rises[i];
        end
        cs_prev[i]   = cs;
        sclk_prev[i] = sclk;
    endtask

    always @(negedge clk) begin
        cyc++;
        model_step(0, en0, cs0, sclk0, busy0, valid0, smp0);
        model_step(1, en1, cs1, sclk1, busy1, valid1, smp1);
        observe(0, cs0, sclk0, valid0, smp0);
        observe(1, cs1, sclk1, valid1, smp1);
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(int i, int budget, string name);
        int n0;
        int k;
        n0 = valid_cnt[i];
        k  = 0;
        while (valid_cnt[i] == n0 && k < budget) begin
            step(1);
            k++;
        end
        checks++;
        if (valid_cnt[i] == n0) begin
            errors++;
            $display("FAIL %s: no sample_valid within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_fall(int i, int budget, string name);
        int n0;
        int k;
        n0 = fall_cnt[i];
        k  = 0;
        while (fall_cnt[i] == n0 && k < budget) begin
            step(1);
            k++;
        end
        checks++;
        if (fall_cnt[i] == n0) begin
            errors++;
            $display("FAIL %s: no adc_cs_n fall within %0d cycles", name, budget);
        end
    endtask

    logic [11:0] p_words [3] = '{12'h000, 12'hFFF, 12'h5A5};
    int          p_exp   [3] = '{8'h00, 8'hFF, 8'h5A};

    initial begin
        int e_rise;
        int n_fall;
        int n_valid;
        rst     = 1'b0;
        en0     = 1'b0;
        en1     = 1'b0;
        word[0] = 12'hABC;
        lead[0] = 3'b111;
        word[1] = 12'h801;
        lead[1] = 3'b111;

        // reset and long idle
        step(5);
        chk("reset cs_n", cs0, 1);
        chk("reset sclk", sclk0, 0);
        chk("reset sample", smp0, 0);
        rst = 1'b1;
        step(2000);
        chk("idle frame starts", fall_cnt[0], 0);
        chk("idle strobes", valid_cnt[0], 0);

        // single frame
        en0    = 1'b1;
        e_rise = cyc + 1;
        wait_valid(0, 1300, "single frame");
        chk("cs_n fall after en", fall_cyc[0] - e_rise, 1024);
        chk("frame length", valid_cyc[0] - fall_cyc[0], 124);
        chk("single sample", smp_v[0], 8'hAB);
        chk("sclk rises per frame", rises_fr[0], 15);

        // periodic operation
        for (int k = 0; k < 3; k++) begin
            word[0] = p_words[k];
            wait_valid(0, 1100, "periodic frame");
            chk("periodic sample", smp_v[0], p_exp[k]);
            chk("strobe spacing", valid_cyc[0] - valid_prev[0], 1024);
        end

        // en dropped mid-frame
        word[0] = 12'h3C7;
        wait_fall(0, 1100, "frame before en drop");
        step(39);
        en0 = 1'b0;
        wait_valid(0, 200, "frame after en drop");
        chk("en-drop sample", smp_v[0], 8'h3C);
        chk("en-drop frame length", valid_cyc[0] - fall_cyc[0], 124);
        n_fall = fall_cnt[0];
        step(2000);
        chk("no frames while disabled", fall_cnt[0] - n_fall, 0);
        word[0] = 12'h123;
        en0     = 1'b1;
        e_rise  = cyc + 1;
        wait_fall(0, 1100, "frame after re-enable");
        chk("cs_n fall after re-enable", fall_cyc[0] - e_rise, 1024);

        // reset mid-frame
        step(59);
        n_valid = valid_cnt[0];
        rst     = 1'b0;
        @(negedge clk);
        #1;
        chk("mid-frame reset sclk", sclk0, 0);
        chk("mid-frame reset cs_n", cs0, 1);
        chk("mid-frame reset sample", smp0, 0);
        chk("mid-frame reset busy", busy0, 0);
        step(3);
        rst     = 1'b1;
        e_rise  = cyc + 1;
        word[0] = 12'hE71;
        step(500);
        chk("no strobe after reset", valid_cnt[0] - n_valid, 0);
        wait_valid(0, 900, "frame after reset");
        chk("cs_n fall after reset release", fall_cyc[0] - e_rise, 1024);
        chk("post-reset frame length", valid_cyc[0] - fall_cyc[0], 124);
        chk("post-reset sample", smp_v[0], 8'hE7);

        // CLK_DIV=1, SAMPLE_PERIOD=40
        en0    = 1'b0;
        en1    = 1'b1;
        e_rise = cyc + 1;
        wait_valid(1, 100, "fast frame");
        chk("fast cs_n fall after en", fall_cyc[1] - e_rise, 40);
        chk("fast frame length", valid_cyc[1] - fall_cyc[1], 31);
        chk("fast sample", smp_v[1], 8'h80);
        chk("fast sclk rises", rises_fr[1], 15);
        wait_valid(1, 60, "fast second frame");
        chk("fast strobe spacing", valid_cyc[1] - valid_prev[1], 40);
        chk("fast second sample", smp_v[1], 8'h80);
        step(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mic_adc_sampler.md
# mic_adc_sampler

- Upstream stage of the microphone delay path.
- Periodically runs an SPI conversion frame on an external 12-bit serial ADC and truncates the result to 8 bits.
- Presents the 8-bit sample with a one-cycle `sample_valid` strobe, which drives the delay stage's write/read enables and `mic_signal` input.
- Owns the audio sample rate: one sample every `SAMPLE_PERIOD` clocks while enabled.

## Interface

Parameters:
- `CLK_DIV`, default 4: SCLK half-period in clk cycles; must be ≥ 1.
- `SAMPLE_PERIOD`, default 1024: clk cycles between conversion starts; must exceed the frame length (see Timing).
- `LEAD_BITS`, default 3: SCLK cycles at frame start whose MISO is discarded (sample/null bits).
- `ADC_BITS`, default 12: data bits per frame, MSB first.
- `OUT_WIDTH`, default 8: output sample width; must be ≤ `ADC_BITS`.

Ports:
- `clk`  input  1  system clock; single clock domain.
- `rst`  input  1  asynchronous, active-low reset.
- `en`  input  1  sampling enable.
- `adc_miso`  input  1  ADC serial data; already synchronised externally.
- `adc_sclk`  output  1  ADC serial clock; idles low.
- `adc_cs_n`  output  1  ADC chip select; active low.
- `sample`  output  OUT_WIDTH  latest sample: top `OUT_WIDTH` bits of the ADC word, unsigned.
- `sample_valid`  output  1  one-cycle strobe; `sample` is new this cycle.
- `busy`  output  1  high while a frame is in progress (`adc_cs_n` low).

## Operation

**Sample timer**
- `SAMPLE_PERIOD`-modulo counter, counting from 0.
- Advances only while `en` is high; cleared to 0 in any cycle `en` is low.
- `tick` fires in the cycle the counter equals `SAMPLE_PERIOD-1` and `en` is high; the counter wraps to 0 on that cycle.

**State machine: IDLE → SETUP → SCLK_LO ⇄ SCLK_HI → DONE → IDLE**
- IDLE: `adc_cs_n`=1, `adc_sclk`=0. On `tick`, go to SETUP and drive `adc_cs_n` low.
- SETUP: hold for `CLK_DIV` cycles with `adc_sclk`=0, then go to SCLK_LO.
- SCLK_LO: hold for `CLK_DIV` cycles. On the final cycle:
  - register `adc_miso` into the shift register (shift left, LSB in);
  - drive `adc_sclk` high;
  - go to SCLK_HI.
- SCLK_HI: hold for `CLK_DIV` cycles, then drive `adc_sclk` low.
  - Bit counter < `LEAD_BITS+ADC_BITS`: go to SCLK_LO.
  - Otherwise: go to DONE.
- DONE, one cycle:
  - `adc_cs_n` goes high;
  - `sample` ← shift register bits [ADC_BITS-1 : ADC_BITS-OUT_WIDTH];
  - `sample_valid`=1;
  - go to IDLE.

**Shift register and bit counter**
- Shift register is `ADC_BITS` wide. Lead bits shift out of the top, so only the last `ADC_BITS` captured bits survive.
- Bit counter increments on each capture and is cleared in IDLE.

**Boundary conditions**
- `tick` while not IDLE: ignored. No queuing and no error flag; the parameter constraint prevents this case.
- `en` falls mid-frame: the frame completes normally and `sample_valid` still fires. The timer clears.
- `en` re-asserted: the next `tick` fires `SAMPLE_PERIOD` cycles later.
- `rst` asserted at any time, including mid-frame:
  - outputs go immediately to reset values: `adc_sclk`=0, `adc_cs_n`=1, `sample`=0, `sample_valid`=0, `busy`=0;
  - timer, bit counter and shift register go to 0; state goes to IDLE;
  - no partial sample is emitted.
- `sample` holds its value between strobes.

## Timing

- **Tick to frame start:** `adc_cs_n` falls one cycle after `tick`.
- **Frame length**, from `adc_cs_n` fall to `sample_valid`: `CLK_DIV*(1 + 2*(LEAD_BITS+ADC_BITS))` cycles. Defaults: 4*(1+30) = 124 cycles.
- **Strobe alignment:** `sample_valid` and `adc_cs_n` rising occur in the same cycle.
- **Frame count:** exactly `LEAD_BITS+ADC_BITS` (default 15) SCLK rising edges per frame.
- **MISO capture:** sampled on the clk edge that raises SCLK, i.e. at the end of the low phase.
- **Steady-state rate:** with `en` continuously high, one `sample_valid` every `SAMPLE_PERIOD` cycles.
- **First sample:** the first `tick` occurs `SAMPLE_PERIOD` cycles after `en` rises.
- **Parameter constraint:** requires `SAMPLE_PERIOD` > frame length + 2.

## Test plan

1. **Reset values and idle:** hold `rst` low, then release with `en`=0 for 2000 cycles. Required: `adc_cs_n`=1, `adc_sclk`=0, `sample`=0, `sample_valid`=0, `busy`=0 throughout.
2. **Single frame:** defaults; ADC model drives lead bits 1,1,1 then 0xABC MSB first; raise `en`.
   - `adc_cs_n` falls at cycle 1024 after `en`;
   - 15 SCLK rising edges, each with 4-cycle high and 4-cycle low phases;
   - `sample`=0xAB with a single-cycle `sample_valid` 124 cycles after `adc_cs_n` fall.
3. **Periodic operation:** `en` held high; model returns 0x000, 0xFFF, 0x5A5 in successive frames.
   - Samples are 0x00, 0xFF, 0x5A;
   - `sample_valid` strobes exactly 1024 cycles apart.
4. **`en` dropped mid-frame:** deassert `en` 40 cycles into a frame.
   - The frame completes and `sample_valid` fires.
   - No further frames start.
   - After re-enable, the next `adc_cs_n` fall is 1024 cycles later.
5. **Reset mid-frame:** assert `rst` 60 cycles into a frame.
   - Same cycle: `adc_sclk`=0, `adc_cs_n`=1, `sample`=0.
   - No `sample_valid` appears.
   - After release with `en` high, the first frame completes correctly.
6. **CLK_DIV=1, SAMPLE_PERIOD=40:** model returns 0x801.
   - Frame is 31 cycles with 1-cycle SCLK phases.
   - `sample`=0x80; `sample_valid` every 40 cycles.
